// File: rtl/sd_cmd_defs.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_defs (package)
// Brief    : Shared constants, FSM encoding and CRC7 step for the SD CMD PHY.
// Revision : 1.0 - initial release
// ============================================================================
package sd_cmd_defs;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_48   = 2'b01;
    localparam logic [1:0] RESP_136  = 2'b10;

    localparam int FRAME_LEN_48  = 48;
    localparam int FRAME_LEN_136 = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4,
        NCC  = 3'd5
    } state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc7
// Brief    : Serial CRC7 (x^7 + x^3 + 1), one data bit per enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sd_crc7
    import sd_cmd_defs::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 7'h00;
        end else if (clr_i) begin
            crc_q <= 7'h00;
        end else if (en_i) begin
            crc_q <= crc7_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_phy.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_phy
// Brief    : Host-side SD CMD line PHY: serialises commands with CRC7, receives
//            48/136-bit responses. Define SD_CMD_RESP_CRC_CHECK_EN to enable
//            response CRC / end-bit checking.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_phy
    import sd_cmd_defs::*;
#(
    parameter int NCR_MIN     = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int NCC_CYC     = 8
) (
    input  logic         iClock_SD_Host,
    input  logic         iReset,
    input  logic         iStrobe_in,
    input  logic [39:0]  iCmd_in,
    input  logic [1:0]   iResp_type,
    input  logic         iTimeout_enable,
    input  logic         iAck_in,
    input  logic         iCmd_pin,
    output logic         oCmd_pin,
    output logic         oCmd_oe,
    output logic         oAck_out,
    output logic         oSerial_ready,
    output logic         oStrobe_out,
    output logic [135:0] oResponse,
    output logic         oTimeout,
    output logic         oCrc_error
);

    state_t         state_q, state_d;
    logic [39:0]    sh_q, sh_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           none_q, none_d;
    logic           r2_q, r2_d;
    logic           ack_q, ack_d;
    logic [135:0]   resp_q, resp_d;
    logic           tmo_q, tmo_d;

    logic           w_latch, w_start, w_last, w_tx_en, w_tx_bit;
    logic [6:0]     w_tx_crc;
    logic [2:0]     w_crc_idx;

    assign w_latch   = (state_q == IDLE) && iStrobe_in;
    assign w_start   = (state_q == WAIT) && (cnt_q >= 8'(NCR_MIN)) && !iCmd_pin;
    assign w_last    = (state_q == RECV) &&
                       (cnt_q == (r2_q ? 8'(FRAME_LEN_136 - 1) : 8'(FRAME_LEN_48 - 1)));
    assign w_tx_en   = (state_q == SEND) && (cnt_q < 8'd40);
    assign w_crc_idx = 3'(8'd46 - cnt_q);

    sd_crc7 u_tx_crc (
        .clk_i  (iClock_SD_Host),
        .rst_ni (iReset),
        .clr_i  (w_latch),
        .en_i   (w_tx_en),
        .bit_i  (sh_q[39]),
        .crc_o  (w_tx_crc)
    );

    // The CRC register is final by bit 40, so it is muxed straight onto the line.
    always_comb begin
        w_tx_bit = 1'b1;
        if (cnt_q < 8'd40) begin
            w_tx_bit = sh_q[39];
        end else if (cnt_q < 8'd47) begin
            w_tx_bit = w_tx_crc[w_crc_idx];
        end
    end

    always_ff @(posedge iClock_SD_Host or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            none_q  <= 1'b0;
            r2_q    <= 1'b0;
            ack_q   <= 1'b0;
            resp_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            none_q  <= none_d;
            r2_q    <= r2_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        none_d  = none_q;
        r2_d    = r2_q;
        ack_d   = 1'b0;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (iStrobe_in) begin
                    state_d = SEND;
                    sh_d    = iCmd_in;
                    cnt_d   = '0;
                    none_d  = (iResp_type == RESP_NONE);
                    r2_d    = (iResp_type == RESP_136);
                    ack_d   = 1'b1;
                    resp_d  = '0;
                    tmo_d   = 1'b0;
                end
            end
            SEND: begin
                if (cnt_q < 8'd40) begin
                    sh_d = {sh_q[38:0], 1'b0};
                end
                if (cnt_q == 8'd47) begin
                    state_d = none_q ? NCC : WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                if (w_start) begin
                    state_d = RECV;
                    resp_d  = {resp_q[134:0], 1'b0};
                    cnt_d   = 8'd1;
                end else if (iTimeout_enable && (cnt_q >= 8'(TIMEOUT_CYC - 1))) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RECV: begin
                resp_d = {resp_q[134:0], iCmd_pin};
                if (w_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (iAck_in) begin
                    state_d = none_q ? IDLE : NCC;
                    cnt_d   = '0;
                end
            end
            NCC: begin
                // A no-response command serves its turnaround first, then reports completion.
                if (cnt_q == 8'(NCC_CYC - 1)) begin
                    state_d = none_q ? DONE : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    logic [7:0] w_rx_k;
    logic       w_rx_en;
    logic [6:0] w_rx_crc;
    logic       crcerr_q;

    // Frame bit index counted from the start bit; only the covered span feeds the CRC.
    assign w_rx_k  = (state_q == RECV) ? cnt_q : 8'd0;
    assign w_rx_en = (w_start || (state_q == RECV)) &&
                     (r2_q ? ((w_rx_k >= 8'd8) && (w_rx_k <= 8'd127)) : (w_rx_k <= 8'd39));

    sd_crc7 u_rx_crc (
        .clk_i  (iClock_SD_Host),
        .rst_ni (iReset),
        .clr_i  (w_latch),
        .en_i   (w_rx_en),
        .bit_i  (iCmd_pin),
        .crc_o  (w_rx_crc)
    );

    always_ff @(posedge iClock_SD_Host or negedge iReset) begin
        if (!iReset) begin
            crcerr_q <= 1'b0;
        end else if (w_latch) begin
            crcerr_q <= 1'b0;
        end else if (w_last) begin
            crcerr_q <= (w_rx_crc != resp_q[6:0]) || !iCmd_pin;
        end
    end

    assign oCrc_error = crcerr_q;
`else
    assign oCrc_error = 1'b0;
`endif

    assign oCmd_oe       = (state_q == SEND);
    assign oCmd_pin      = oCmd_oe ? w_tx_bit : 1'b1;
    assign oAck_out      = ack_q;
    assign oSerial_ready = (state_q == IDLE) && iReset;
    assign oStrobe_out   = (state_q == DONE);
    assign oResponse     = resp_q;
    assign oTimeout      = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_phy.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_phy
// Brief    : Directed self-checking bench for sd_cmd_phy (command TX, R1/R2 RX,
//            timeout, CRC error, reset abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_phy;

    logic         clk = 1'b0;
    logic         iReset;
    logic         iStrobe_in;
    logic [39:0]  iCmd_in;
    logic [1:0]   iResp_type;
    logic         iTimeout_enable;
    logic         iAck_in;
    logic         iCmd_pin;
    logic         oCmd_pin;
    logic         oCmd_oe;
    logic         oAck_out;
    logic         oSerial_ready;
    logic         oStrobe_out;
    logic [135:0] oResponse;
    logic         oTimeout;
    logic         oCrc_error;

    int checks   = 0;
    int failures = 0;

    sd_cmd_phy dut (
        .iClock_SD_Host  (clk),
        .iReset          (iReset),
        .iStrobe_in      (iStrobe_in),
        .iCmd_in         (iCmd_in),
        .iResp_type      (iResp_type),
        .iTimeout_enable (iTimeout_enable),
        .iAck_in         (iAck_in),
        .iCmd_pin        (iCmd_pin),
        .oCmd_pin        (oCmd_pin),
        .oCmd_oe         (oCmd_oe),
        .oAck_out        (oAck_out),
        .oSerial_ready   (oSerial_ready),
        .oStrobe_out     (oStrobe_out),
        .oResponse       (oResponse),
        .oTimeout        (oTimeout),
        .oCrc_error      (oCrc_error)
    );

    always #5 clk = ~clk;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    localparam logic EXP_BAD = 1'b1;
`else
    localparam logic EXP_BAD = 1'b0;
`endif

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Latch a command and capture the 48 bits driven on CMD.
    task automatic do_cmd(input logic [39:0] cmd, input logic [1:0] typ, output logic [47:0] txw);
        logic oe_ok;
        chk("ready_before_cmd", oSerial_ready, 1);
        iCmd_in    = cmd;
        iResp_type = typ;
        iStrobe_in = 1'b1;
        @(negedge clk);
        iStrobe_in = 1'b0;
        chk("ack_pulse", oAck_out, 1);
        txw[47] = oCmd_pin;
        oe_ok   = (oCmd_oe === 1'b1);
        @(negedge clk);
        chk("ack_one_cycle", oAck_out, 0);
        for (int i = 46; i >= 0; i--) begin
            txw[i] = oCmd_pin;
            if (oCmd_oe !== 1'b1) oe_ok = 1'b0;
            @(negedge clk);
        end
        chk("oe_high_48", oe_ok, 1);
        chk("oe_released", oCmd_oe, 0);
    endtask

    task automatic respond(input logic [135:0] f, input int len, input int dly);
        for (int i = 0; i < dly; i++) begin
            iCmd_pin = 1'b1;
            @(negedge clk);
        end
        for (int i = len - 1; i >= 0; i--) begin
            iCmd_pin = f[i];
            @(negedge clk);
        end
        iCmd_pin = 1'b1;
    endtask

    task automatic wait_strobe(output int k);
        k = 0;
        while (oStrobe_out !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_ack(output int k);
        iAck_in = 1'b1;
        @(negedge clk);
        iAck_in = 1'b0;
        chk("strobe_cleared", oStrobe_out, 0);
        k = 0;
        while (oSerial_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    logic [47:0]  tx;
    logic [47:0]  r1;
    logic [119:0] cid;
    logic [135:0] r2;
    int           k;
    logic         flag;

    initial begin
        iReset = 1'b0; iStrobe_in = 1'b0; iCmd_in = '0; iResp_type = 2'b00;
        iTimeout_enable = 1'b1; iAck_in = 1'b0; iCmd_pin = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_oe", oCmd_oe, 0);
        chk("rst_pin", oCmd_pin, 1);
        chk("rst_ack", oAck_out, 0);
        chk("rst_ready", oSerial_ready, 0);
        chk("rst_strobe", oStrobe_out, 0);
        chk("rst_resp", oResponse, 0);
        chk("rst_tmo", oTimeout, 0);
        chk("rst_crc", oCrc_error, 0);
        iReset = 1'b1;
        @(negedge clk);

        // CMD0, no response
        do_cmd(40'h4000000000, 2'b00, tx);
        chk("cmd0_tx", tx, 48'h400000000095);
        wait_strobe(k);
        chk("cmd0_strobe_lat", k, 8);
        chk("cmd0_tmo", oTimeout, 0);
        chk("cmd0_crc", oCrc_error, 0);
        chk("cmd0_resp", oResponse, 0);
        do_ack(k);
        chk("cmd0_idle_after_ack", k, 0);

        // CMD8, good R7
        do_cmd(40'h48000001AA, 2'b01, tx);
        chk("cmd8_tx", tx, 48'h48000001AA87);
        respond(136'h08000001AA13, 48, 5);
        chk("cmd8_strobe", oStrobe_out, 1);
        chk("cmd8_resp", oResponse, 136'h08000001AA13);
        chk("cmd8_crc", oCrc_error, 0);
        chk("cmd8_tmo", oTimeout, 0);
        do_ack(k);
        chk("cmd8_ncc_len", k, 8);
        chk("cmd8_resp_held", oResponse, 136'h08000001AA13);

        // CMD8, corrupted CRC, then bad end bit
        do_cmd(40'h48000001AA, 2'b11, tx);
        respond(136'h08000001AA15, 48, 5);
        chk("badcrc_strobe", oStrobe_out, 1);
        chk("badcrc_flag", oCrc_error, EXP_BAD);
        do_ack(k);
        do_cmd(40'h48000001AA, 2'b01, tx);
        respond(136'h08000001AA12, 48, 2);
        chk("badend_strobe", oStrobe_out, 1);
        chk("badend_flag", oCrc_error, EXP_BAD);
        do_ack(k);

        // CMD17 timeout
        do_cmd(40'h5100000000, 2'b01, tx);
        chk("cmd17_tx", tx, {40'h5100000000, crc7(136'h5100000000, 40), 1'b1});
        wait_strobe(k);
        chk("tmo_latency", k, 64);
        chk("tmo_flag", oTimeout, 1);
        chk("tmo_resp", oResponse, 0);
        chk("tmo_crc", oCrc_error, 0);
        do_ack(k);

        // CMD17 with timeout disabled: waits, then accepts a late response
        iTimeout_enable = 1'b0;
        do_cmd(40'h5100000000, 2'b01, tx);
        flag = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (oStrobe_out !== 1'b0) flag = 1'b1;
        end
        chk("notmo_no_strobe", flag, 0);
        r1 = {8'h11, 32'h00000900, crc7(136'h1100000900, 40), 1'b1};
        respond({88'h0, r1}, 48, 0);
        chk("late_strobe", oStrobe_out, 1);
        chk("late_resp", oResponse, {88'h0, r1});
        chk("late_crc", oCrc_error, 0);
        do_ack(k);
        iTimeout_enable = 1'b1;

        // CMD2, R2 response, stray strobe ignored, delayed ack
        do_cmd(40'h4200000000, 2'b10, tx);
        iCmd_in    = 40'h4000000000;
        iStrobe_in = 1'b1;
        @(negedge clk);
        iStrobe_in = 1'b0;
        chk("busy_strobe_ignored", oAck_out, 0);
        cid = 120'h0353_4453_4430_3847_8012_3456_7801_3A;
        r2  = {8'h3F, cid, crc7({16'h0, cid}, 120), 1'b1};
        respond(r2, 136, 3);
        chk("r2_strobe", oStrobe_out, 1);
        chk("r2_resp", oResponse, r2);
        chk("r2_crc", oCrc_error, 0);
        flag = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (oStrobe_out !== 1'b1) flag = 1'b0;
        end
        chk("r2_strobe_held", flag, 1);
        do_ack(k);
        chk("r2_ncc_len", k, 8);

        // Reset in the middle of SEND
        iCmd_in    = 40'h48000001AA;
        iResp_type = 2'b01;
        iStrobe_in = 1'b1;
        @(negedge clk);
        iStrobe_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("midsend_oe", oCmd_oe, 1);
        #2 iReset = 1'b0;
        #1;
        chk("abort_oe", oCmd_oe, 0);
        chk("abort_pin", oCmd_pin, 1);
        chk("abort_ready", oSerial_ready, 0);
        chk("abort_strobe", oStrobe_out, 0);
        chk("abort_resp", oResponse, 0);
        chk("abort_tmo", oTimeout, 0);
        @(negedge clk);
        iReset = 1'b1;
        @(negedge clk);
        do_cmd(40'h4000000000, 2'b00, tx);
        chk("post_rst_tx", tx, 48'h400000000095);
        wait_strobe(k);
        chk("post_rst_strobe_lat", k, 8);
        do_ack(k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
